// File: rtl/dm_wt_dcache_if.sv
// Bundle of the MEM-stage request/response signals and the main-memory port of the data cache.
// The master side is the pipeline plus memory environment; the slave side is the cache itself.
interface dm_wt_dcache_if;
    logic        MemReadM;
    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        Hit;
    logic        Stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output MemReadM, MemWriteM, ALUResultM, WriteDataM,
        input  ReadDataM, Hit, Stall,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rvalid, mem_rdata, mem_ready
    );

    modport slave (
        input  MemReadM, MemWriteM, ALUResultM, WriteDataM,
        output ReadDataM, Hit, Stall,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rvalid, mem_rdata, mem_ready
    );
endinterface

// File: rtl/dm_wt_dcache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache with multi-word line refill
// from main memory and a pipeline stall output.
module dm_wt_dcache #(
    parameter int NUM_SETS   = 8,
    parameter int LINE_WORDS = 4
) (
    input  logic          clk,
    input  logic          rst,
    dm_wt_dcache_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int OFS_W = $clog2(LINE_WORDS);
    localparam int TAG_W = 30 - IDX_W - OFS_W;
    localparam logic [OFS_W:0] LAST_BEAT = (OFS_W+1)'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

    state_t            r_state;
    logic [NUM_SETS-1:0] r_valid;
    logic [TAG_W-1:0]  r_tag  [NUM_SETS];
    logic [31:0]       r_data [NUM_SETS][LINE_WORDS];
    logic [OFS_W:0]    r_beat;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [31:0]       r_mem_addr;
    logic [31:0]       r_mem_wdata;

    logic [OFS_W-1:0]  w_ofs;
    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [IDX_W-1:0]  w_fill_idx;
    logic [TAG_W-1:0]  w_fill_tag;
    logic              w_hit;
    logic              w_wr_hit;
    logic              w_beat;
    logic              w_last;
    logic              w_stall;

    assign w_ofs = bus.ALUResultM[OFS_W+1:2];
    assign w_idx = bus.ALUResultM[IDX_W+OFS_W+1:OFS_W+2];
    assign w_tag = bus.ALUResultM[31:IDX_W+OFS_W+2];

    // The refill target comes from the latched line address; its index/tag bits never change across beats.
    assign w_fill_idx = r_mem_addr[IDX_W+OFS_W+1:OFS_W+2];
    assign w_fill_tag = r_mem_addr[31:IDX_W+OFS_W+2];

    assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_wr_hit = (r_state == IDLE) && bus.MemWriteM && w_hit;
    assign w_beat   = (r_state == REFILL) && bus.mem_rvalid;
    assign w_last   = (r_beat == LAST_BEAT);

    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            IDLE:    w_stall = bus.MemWriteM || (bus.MemReadM && !w_hit);
            REFILL:  w_stall = 1'b1;
            WRITE:   w_stall = !bus.mem_ready;
            default: w_stall = 1'b0;
        endcase
    end

    // Storage arrays carry no reset; writes are suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (w_wr_hit)
                r_data[w_idx][w_ofs] <= bus.WriteDataM;
            if (w_beat) begin
                r_data[w_fill_idx][r_beat[OFS_W-1:0]] <= bus.mem_rdata;
                if (w_last)
                    r_tag[w_fill_idx] <= w_fill_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_valid     <= '0;
            r_beat      <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.MemWriteM) begin
                        r_state     <= WRITE;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= {bus.ALUResultM[31:2], 2'b00};
                        r_mem_wdata <= bus.WriteDataM;
                    end else if (bus.MemReadM && !w_hit) begin
                        r_state    <= REFILL;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= {bus.ALUResultM[31:OFS_W+2], {(OFS_W+2){1'b0}}};
                        r_beat     <= '0;
                    end
                end
                REFILL: begin
                    if (bus.mem_rvalid) begin
                        if (w_last) begin
                            r_valid[w_fill_idx] <= 1'b1;
                            r_state             <= IDLE;
                            r_mem_req           <= 1'b0;
                            r_beat              <= '0;
                        end else begin
                            r_beat     <= r_beat + 1'b1;
                            r_mem_addr <= r_mem_addr + 32'd4;
                        end
                    end
                end
                WRITE: begin
                    // Leaving on acceptance coincides with the pipeline advancing, so the store is not reissued.
                    if (bus.mem_ready) begin
                        r_state   <= IDLE;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.Hit       = w_hit;
    assign bus.ReadDataM = w_hit ? r_data[w_idx][w_ofs] : 32'd0;
    assign bus.Stall     = w_stall;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: doc/dm_wt_dcache.md
Name: dm_wt_dcache

Overview:
- Parametrised direct-mapped L1 data cache in the memory stage; successor to the single-word, write-only-fill cache.
- Adds multi-word lines, a read-miss refill state machine to main memory, write-through stores, and a pipeline stall output.
- Sits between the MEM stage (ALUResultM, WriteDataM, MemReadM, MemWriteM) and the main data memory. ReadDataM feeds ReadDataW.

Parameters:
- NUM_SETS, 8, number of lines; power of 2, ≥2.
- LINE_WORDS, 4, 32-bit words per line; power of 2, ≥2.
- Derived (localparams, not user-set): IDX_W=log2(NUM_SETS), OFS_W=log2(LINE_WORDS), TAG_W=30-IDX_W-OFS_W.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset.
- MemReadM  in  1  load request.
- MemWriteM  in  1  store request.
- ALUResultM  in  32  byte address; bits [1:0] ignored (word access only).
- WriteDataM  in  32  store data.
- ReadDataM  out  32  load data.
- Hit  out  1  lookup hit (valid & tag match).
- Stall  out  1  freeze pipeline.
- mem_req  out  1  memory request.
- mem_we  out  1  1=write, 0=read.
- mem_addr  out  32  word-aligned memory address.
- mem_wdata  out  32  write data.
- mem_rvalid  in  1  read beat valid.
- mem_rdata  in  32  read beat data.
- mem_ready  in  1  write accepted.

Behaviour:
- Address split:
  - word offset = ALUResultM[OFS_W+1:2]
  - index = ALUResultM[IDX_W+OFS_W+1:OFS_W+2]
  - tag = ALUResultM[31:IDX_W+OFS_W+2]
- Storage: valid[NUM_SETS], tag[NUM_SETS], data[NUM_SETS][LINE_WORDS]. Data and tag arrays are not reset.
- Hit (combinational) = valid[index] && tag[index]==tag, in every state.
- ReadDataM (combinational) = data[index][offset] when Hit, else 0.
- FSM states IDLE, REFILL, WRITE. Reset state is IDLE.
- IDLE, MemWriteM=1 (takes priority over MemReadM):
  - Stall=1, next state WRITE.
  - If Hit, write WriteDataM into data[index][offset] on this edge. No allocate on a store miss.
  - Store address and data are latched.
- IDLE, MemReadM=1 and !Hit:
  - Stall=1, next state REFILL.
  - Latch line base address (offset bits zeroed); beat counter cleared to 0.
- IDLE, read hit or no request: Stall=0, mem_req=0. A read hit has zero extra latency.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr = latched base + 4*beat.
  - On each mem_rvalid: data[index][beat] <= mem_rdata; beat increments.
  - On the beat with beat==LINE_WORDS-1: set valid[index]=1 and tag[index]=latched tag, return to IDLE.
  - Stall=1 throughout.
  - The next IDLE cycle sees a hit and drops Stall, so a read miss costs LINE_WORDS beats + 1 cycle minimum.
- WRITE:
  - mem_req=1, mem_we=1, mem_addr/mem_wdata = latched values.
  - Stall = !mem_ready.
  - On mem_ready: return to IDLE on the same edge the pipeline advances, so the store is not reissued.
  - Requests are held stable until accepted.
- mem_rvalid outside REFILL is ignored. mem_ready outside WRITE is ignored.
- Beat counter width is OFS_W+1; it never wraps past LINE_WORDS-1 inside REFILL.
- Reset values (rst=0 at a clock edge):
  - all valid=0, state=IDLE, beat=0.
  - Hence Hit=0, ReadDataM=0, Stall=0 with no request, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset mid-REFILL: the partial line is discarded (valid stays 0) and mem_req drops in the cycle after reset is sampled.
- Reset mid-WRITE: the store is abandoned.
- A refill overwrites any prior line at that index (conflict eviction). No dirty state exists (write-through).

Test Plan:
- Reset: rst=0 for 2 cycles, then read 0x40 -> Hit=0, Stall=1, state REFILL, mem_addr=0x40.
- Read-miss refill (LINE_WORDS=4): memory returns 0xA0..0xA3 with rvalid each cycle -> mem_addr steps 0x40,0x44,0x48,0x4C. One cycle after the last beat, read 0x48 -> Hit=1, ReadDataM=0xA2, Stall=0.
- Write-through hit: after the refill above, store 0x1234 to 0x44 with mem_ready delayed 3 cycles -> Stall=1 for 3 cycles; mem_req=1, mem_we=1, mem_addr=0x44, mem_wdata=0x1234. Then read 0x44 -> Hit=1, ReadDataM=0x1234.
- Write miss: store 0x5555 to 0x400 -> memory write issued; read 0x400 afterwards -> Hit=0 (no allocate).
- Conflict eviction (NUM_SETS=8, LINE_WORDS=4): fill 0x40, then read 0x240 (same index, new tag) -> refill. A read of 0x40 then misses.
- Reset mid-refill: rst=0 after 2 of 4 beats -> mem_req=0 next cycle. A read of 0x40 then misses and restarts the refill at beat 0.
